value_entry_storage: RTL

//   Parametrised button-entry value register for the I/O subsystem: debounces four buttons

---
 rtl/value_entry_storage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/value_entry_storage.sv
// Button-entry value register: debounces four buttons on the timer tick, shifts binary
// digits into a WIDTH-bit value, sends snapshots over valid/ready, and accepts bus loads.
module value_entry_storage #(
    parameter int WIDTH          = 8,
    parameter int LED_WIDTH      = 4,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       timer_tick,
    input  logic [3:0]                 buttons,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH-1:0]           value,
    output logic [LED_WIDTH-1:0]       leds,
    output logic                       overflow,
    output logic [$clog2(WIDTH+1)-1:0] digit_count
);

    localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int DCW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_TICKS);
    localparam logic [DCW-1:0] DC_MAX  = DCW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_SEND    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_upd_s;
    logic              press_s, release_s;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic [DCW-1:0]    digit_count_q, digit_count_d;

    // Debounce: track the last sample and how many consecutive ticks it has been seen.
    always_comb begin
        last_d    = last_q;
        cnt_upd_s = cnt_q;
        press_s   = 1'b0;
        release_s = 1'b0;
        if (timer_tick) begin
            last_d = buttons;
            if (buttons == last_q) begin
                cnt_upd_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cnt_upd_s = CW'(1);
            end
            // A change of sample re-arms acceptance even when the counter is already at max.
            if ((cnt_upd_s == CNT_MAX) && ((cnt_q != CNT_MAX) || (buttons != last_q))) begin
                if (buttons != 4'b0000) begin
                    press_s = 1'b1;
                end else begin
                    release_s = 1'b1;
                end
            end else begin
                press_s   = 1'b0;
                release_s = 1'b0;
            end
        end else begin
            cnt_upd_s = cnt_q;
        end
    end

    // Entry FSM, button actions, bus load and send handshake.
    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        overflow_d    = overflow_q;
        digit_count_d = digit_count_q;
        cnt_d         = cnt_upd_s;
        case (state_q)
            ST_IDLE: begin
                if (press_s) begin
                    if (buttons[2:0] != 3'b000) begin
                        state_d = ST_RELEASE;
                    end else if (in_valid) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d     = ST_SEND;
                        out_valid_d = 1'b1;
                        out_data_d  = value_q;
                    end
                    if (!in_valid && (buttons[1:0] != 2'b00)) begin
                        value_d       = {value_q[WIDTH-2:0], buttons[0]};
                        overflow_d    = overflow_q | value_q[WIDTH-1];
                        digit_count_d = (digit_count_q == DC_MAX) ? digit_count_q
                                                                  : digit_count_q + DCW'(1);
                    end else if (!in_valid && buttons[2]) begin
                        value_d       = '0;
                        overflow_d    = 1'b0;
                        digit_count_d = '0;
                    end else begin
                        value_d = value_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (release_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        if (in_valid) begin
            value_d       = in_data;
            overflow_d    = 1'b0;
            digit_count_d = '0;
        end else begin
            value_d = value_d;
        end
        // Every state change needs fresh samples; a tick coinciding with the handshake
        // already counts as the first sample of the release phase.
        if (state_d != state_q) begin
            cnt_d = (state_q == ST_SEND && timer_tick) ? CW'(1) : CW'(0);
        end else begin
            cnt_d = cnt_upd_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= 4'b0000;
            cnt_q         <= '0;
            value_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            digit_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overflow_q    <= overflow_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign value       = value_q;
    assign leds        = value_q[LED_WIDTH-1:0];
    assign overflow    = overflow_q;
    assign digit_count = digit_count_q;

endmodule
